// File: rtl/input_conditioner.sv
// input_conditioner
//   Front end between board switches/pushbuttons and the SoC. Every pin is
//   synchronised and debounced on its own. Keys are turned active-high. The
//   block also produces press/release strobes, a switch-change strobe, and
//   auto-repeat pulses for keys that stay held.
//
//   Ports
//     clk          system clock (CLOCK_50 domain)
//     reset        synchronous, active-high
//     sw_raw       raw slider switches (async)
//     key_n_raw    raw pushbuttons, active-low (async)
//     sw_stable    debounced switch levels
//     sw_changed   1-cycle pulse when any sw_stable bit changes
//     key_down     debounced key levels, 1 = pressed
//     key_press    1-cycle pulse per key on debounced press
//     key_release  1-cycle pulse per key on debounced release
//     key_repeat   1-cycle auto-repeat pulse per held key

// Per-pin lane: synchroniser chain followed by the debounce counter.
// 'accept' is high in the cycle whose edge flips 'stable'. Downstream logic
// uses it to see a level change one edge early.
module ic_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter bit RST_LVL         = 1'b0,
  parameter bit INVERT          = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic accept
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= {SYNC_STAGES{RST_LVL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  assign synced = sync_q[SYNC_STAGES-1] ^ INVERT;
  assign accept = (synced != stable) && (cnt == LAST);

  // A glitch back to the stable level clears the count; no partial credit.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (synced == stable) begin
      cnt    <= '0;
    end else if (accept) begin
      stable <= synced;
      cnt    <= '0;
    end else begin
      cnt    <= cnt + CW'(1);
    end
  end
endmodule

// Per-key auto-repeat FSM.
//   press : high on the edge that registers key_press, so the DELAY count
//           starts together with the press strobe.
//   rel   : high on the edge where key_down falls. Leaving here means no
//           repeat pulse can appear in that cycle or afterwards.
module ic_key_repeat #(
  parameter int REPEAT_DELAY  = 32,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic press,
  input  logic rel,
  output logic rpt
);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] D_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] P_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, RPT} state_t;
  state_t        st;
  logic [RW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= IDLE;
      cnt <= '0;
      rpt <= 1'b0;
    end else begin
      rpt <= 1'b0;
      case (st)
        IDLE: begin
          if (press) begin
            st  <= DELAY;
            cnt <= '0;
          end
        end
        DELAY: begin
          if (rel) begin
            st  <= IDLE;
            cnt <= '0;
          end else if (cnt == D_LAST) begin
            rpt <= 1'b1;
            st  <= RPT;
            cnt <= '0;
          end else begin
            cnt <= cnt + RW'(1);
          end
        end
        RPT: begin
          if (rel) begin
            st  <= IDLE;
            cnt <= '0;
          end else if (cnt == P_LAST) begin
            rpt <= 1'b1;
            cnt <= '0;
          end else begin
            cnt <= cnt + RW'(1);
          end
        end
        default: begin
          st  <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end
endmodule

module input_conditioner #(
  parameter int N_SW            = 10,
  parameter int N_KEY           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_KEY-1:0] key_n_raw,
  output logic [N_SW-1:0]  sw_stable,
  output logic             sw_changed,
  output logic [N_KEY-1:0] key_down,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release,
  output logic [N_KEY-1:0] key_repeat
);
  logic [N_SW-1:0]  sw_accept;
  logic [N_KEY-1:0] key_accept;
  logic [N_KEY-1:0] key_rise, key_fall;
  logic             sw_chg_q;
  logic [N_KEY-1:0] rise_q, fall_q;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    ic_debounce #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RST_LVL(1'b0), .INVERT(1'b0)
    ) u_db (
      .clk(clk), .reset(reset), .pin(sw_raw[i]),
      .stable(sw_stable[i]), .accept(sw_accept[i])
    );
  end

  // Key synchronisers reset to the released (high) pin level, and the lane
  // inverts after the last stage.
  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    ic_debounce #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RST_LVL(1'b1), .INVERT(1'b1)
    ) u_db (
      .clk(clk), .reset(reset), .pin(key_n_raw[i]),
      .stable(key_down[i]), .accept(key_accept[i])
    );

    ic_key_repeat #(
      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_rpt (
      .clk(clk), .reset(reset), .press(rise_q[i]), .rel(key_fall[i]),
      .rpt(key_repeat[i])
    );
  end

  assign key_rise = key_accept & ~key_down;
  assign key_fall = key_accept &  key_down;

  // Two flop stages: the first lines up with the stable-bit update, and the
  // second puts the strobe one cycle after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_chg_q    <= 1'b0;
      sw_changed  <= 1'b0;
      rise_q      <= '0;
      fall_q      <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      sw_chg_q    <= |sw_accept;
      sw_changed  <= sw_chg_q;
      rise_q      <= key_rise;
      fall_q      <= key_fall;
      key_press   <= rise_q;
      key_release <= fall_q;
    end
  end
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with small debounce/repeat constants.
// Inputs are driven and outputs are sampled on the falling clock edge. After
// an input changes at a falling edge, the k-th following falling edge is
// called "step k".
module tb_input_conditioner;
  localparam int N_SW  = 10;
  localparam int N_KEY = 4;

  logic             CLOCK_50 = 1'b0;
  logic             reset;
  logic [N_SW-1:0]  sw_raw;
  logic [N_KEY-1:0] key_n_raw;
  logic [N_SW-1:0]  sw_stable;
  logic             sw_changed;
  logic [N_KEY-1:0] key_down, key_press, key_release, key_repeat;

  always #10 CLOCK_50 = ~CLOCK_50;

  input_conditioner #(
    .N_SW(N_SW), .N_KEY(N_KEY), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY(32), .REPEAT_PERIOD(16)
  ) dut (
    .clk(CLOCK_50), .reset(reset), .sw_raw(sw_raw), .key_n_raw(key_n_raw),
    .sw_stable(sw_stable), .sw_changed(sw_changed), .key_down(key_down),
    .key_press(key_press), .key_release(key_release), .key_repeat(key_repeat)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLOCK_50);
  endtask

  // Pulse counters used to check "exactly one pulse" style properties.
  int chg_cnt = 0;
  int press_cnt [N_KEY] = '{default: 0};
  int rel_cnt   [N_KEY] = '{default: 0};
  int rep_cnt   [N_KEY] = '{default: 0};

  always @(negedge CLOCK_50) begin
    if (!reset) begin
      chg_cnt += int'(sw_changed);
      for (int i = 0; i < N_KEY; i++) begin
        press_cnt[i] += int'(key_press[i]);
        rel_cnt[i]   += int'(key_release[i]);
        rep_cnt[i]   += int'(key_repeat[i]);
      end
    end
  end

  int   base_chg, base_p, base_r, base_rep;
  int   p_step, r_step, f_step, n_rep;
  int   rep_at [3];
  logic bad, ovl;

  initial begin
    reset     = 1'b1;
    sw_raw    = '0;
    key_n_raw = '1;
    repeat (3) step();
    chk("rst_sw_stable",   32'(sw_stable),   32'h0);
    chk("rst_key_down",    32'(key_down),    32'h0);
    chk("rst_sw_changed",  32'(sw_changed),  32'h0);
    chk("rst_key_press",   32'(key_press),   32'h0);
    chk("rst_key_release", 32'(key_release), 32'h0);
    chk("rst_key_repeat",  32'(key_repeat),  32'h0);
    reset = 1'b0;
    repeat (20) step();
    // Pins were at their reset levels, so nothing may fire after reset.
    chk("idle_sw_stable", 32'(sw_stable), 32'h0);
    chk("idle_key_down",  32'(key_down),  32'h0);
    chk("idle_chg_cnt",   32'(chg_cnt),   32'h0);

    // Clean edge: stable after exactly 10 steps, strobe on step 11 only.
    base_chg = chg_cnt;
    sw_raw   = 10'h001;
    repeat (9) step();
    chk("clean_pre",     32'(sw_stable),  32'h000);
    step();
    chk("clean_lat",     32'(sw_stable),  32'h001);
    chk("clean_chg_lat", 32'(sw_changed), 32'h0);
    step();
    chk("clean_chg_on",  32'(sw_changed), 32'h1);
    step();
    chk("clean_chg_off", 32'(sw_changed), 32'h0);
    repeat (5) step();
    chk("clean_chg_cnt", 32'(chg_cnt - base_chg), 32'h1);

    // Bounce: toggle sw[3] every 5 cycles for 100 cycles, then settle at 1.
    base_chg = chg_cnt;
    bad      = 1'b0;
    for (int t = 0; t < 20; t++) begin
      sw_raw[3] = ~sw_raw[3];
      repeat (5) begin
        step();
        bad |= sw_stable[3];
      end
    end
    chk("bounce_held_low", 32'(bad), 32'h0);
    sw_raw[3] = 1'b1;
    repeat (9) step();
    chk("bounce_pre", 32'(sw_stable), 32'h001);
    step();
    chk("bounce_lat", 32'(sw_stable), 32'h009);
    repeat (5) step();
    chk("bounce_chg_cnt", 32'(chg_cnt - base_chg), 32'h1);

    // Key 0 held low for 20 cycles.
    base_p   = press_cnt[0];
    base_r   = rel_cnt[0];
    base_rep = rep_cnt[0];
    key_n_raw[0] = 1'b0;
    repeat (9) step();
    chk("k0_pre",       32'(key_down),  32'h0);
    step();
    chk("k0_down",      32'(key_down),  32'h1);
    chk("k0_press_lat", 32'(key_press), 32'h0);
    step();
    chk("k0_press_on",  32'(key_press), 32'h1);
    step();
    chk("k0_press_off", 32'(key_press), 32'h0);
    repeat (8) step();
    key_n_raw[0] = 1'b1;
    repeat (9) step();
    chk("k0_still_down", 32'(key_down),    32'h1);
    step();
    chk("k0_up",         32'(key_down),    32'h0);
    step();
    chk("k0_release",    32'(key_release), 32'h1);
    repeat (40) step();
    chk("k0_press_cnt", 32'(press_cnt[0] - base_p),   32'h1);
    chk("k0_rel_cnt",   32'(rel_cnt[0]   - base_r),   32'h1);
    chk("k0_rep_cnt",   32'(rep_cnt[0]   - base_rep), 32'h0);

    // Auto-repeat on key 2. The key is held low for 70 cycles, so key_down
    // is high on steps 10..79. key_press appears on step 11. Repeats follow
    // at 11+32 = 43, then 59 and 75. The next one would be at 91, after the
    // release, so exactly three repeats are expected.
    p_step = 0; r_step = 0; f_step = 0; n_rep = 0; ovl = 1'b0;
    rep_at = '{default: 0};
    key_n_raw[2] = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (key_press[2])   p_step = k;
      if (key_release[2]) r_step = k;
      if (key_down[2])    f_step = k;
      if (key_repeat[2]) begin
        if (n_rep < 3) rep_at[n_rep] = k;
        n_rep++;
      end
      ovl |= key_press[2] & key_repeat[2];
      if (k == 70) key_n_raw[2] = 1'b1;
    end
    chk("rpt_press_step", 32'(p_step),    32'd11);
    chk("rpt_first",      32'(rep_at[0]), 32'd43);
    chk("rpt_second",     32'(rep_at[1]), 32'd59);
    chk("rpt_third",      32'(rep_at[2]), 32'd75);
    chk("rpt_count",      32'(n_rep),     32'd3);
    chk("rpt_last_down",  32'(f_step),    32'd79);
    chk("rpt_rel_step",   32'(r_step),    32'd81);
    chk("rpt_no_overlap", 32'(ovl),       32'h0);

    // Simultaneous change on every switch and key.
    sw_raw = '0;
    repeat (20) step();
    base_chg  = chg_cnt;
    sw_raw    = 10'h3FF;
    key_n_raw = 4'h0;
    repeat (9) step();
    chk("sim_sw_pre",   32'(sw_stable), 32'h000);
    chk("sim_key_pre",  32'(key_down),  32'h0);
    step();
    chk("sim_sw",       32'(sw_stable), 32'h3FF);
    chk("sim_key",      32'(key_down),  32'hF);
    step();
    chk("sim_chg_on",   32'(sw_changed), 32'h1);
    chk("sim_press_on", 32'(key_press),  32'hF);
    step();
    chk("sim_chg_off",  32'(sw_changed), 32'h0);
    chk("sim_press_off",32'(key_press),  32'h0);
    chk("sim_chg_cnt",  32'(chg_cnt - base_chg), 32'h1);
    key_n_raw = 4'hF;
    sw_raw    = '0;
    repeat (30) step();

    // Reset mid-debounce. SW0 and KEY1 are already accepted, and SW1 is
    // 5 cycles into its debounce when reset is applied.
    sw_raw    = 10'h001;
    key_n_raw = 4'b1101;
    repeat (14) step();
    chk("mid_setup_sw",  32'(sw_stable), 32'h001);
    chk("mid_setup_key", 32'(key_down),  32'h2);
    sw_raw = 10'h003;
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("mid_rst_sw",      32'(sw_stable),  32'h000);
    chk("mid_rst_key",     32'(key_down),   32'h0);
    chk("mid_rst_pulses",  32'({sw_changed, key_press, key_release, key_repeat}), 32'h0);
    repeat (2) step();
    reset = 1'b0;
    repeat (9) step();
    chk("mid_pre_sw",   32'(sw_stable), 32'h000);
    step();
    chk("mid_post_sw",  32'(sw_stable), 32'h003);
    chk("mid_post_key", 32'(key_down),  32'h2);
    step();
    chk("mid_post_chg",   32'(sw_changed), 32'h1);
    chk("mid_post_press", 32'(key_press),  32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
